// File: rtl/vga_pkg.sv
// Shared 640x480@60Hz timing constants and stage-1 pipeline record for the
// VGA raster scan generator.
package vga_pkg;

   localparam int DIV_DEF    = 4;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int H_ACT_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;
   localparam int V_ACT_DEF  = 480;
   localparam int V_FP_DEF   = 10;

   localparam int H_TOT = H_SYNC_DEF + H_BP_DEF + H_ACT_DEF + H_FP_DEF;
   localparam int V_TOT = V_SYNC_DEF + V_BP_DEF + V_ACT_DEF + V_FP_DEF;

   // Visible window is [LO, HI) in counter space; sync occupies the start of each period.
   localparam int H_VIS_LO = H_SYNC_DEF + H_BP_DEF;
   localparam int H_VIS_HI = H_VIS_LO + H_ACT_DEF;
   localparam int V_VIS_LO = V_SYNC_DEF + V_BP_DEF;
   localparam int V_VIS_HI = V_VIS_LO + V_ACT_DEF;

   typedef struct packed {
      logic [8:0] row;
      logic [9:0] col;
      logic       rdn;
      logic       hs_raw;
      logic       vs_raw;
   } s1_t;

   localparam s1_t S1_RST = '{row: 9'd0, col: 10'd0, rdn: 1'b1, hs_raw: 1'b1, vs_raw: 1'b1};

   function automatic logic in_win(input logic [9:0] c, input logic [9:0] lo,
                                   input logic [9:0] hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/vga_scan_pix_tick_gen.sv
// Pixel-rate enable: asserts tick for one clk out of every DIV clks.
module pix_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] dcnt_q, dcnt_d;

   assign tick = (dcnt_q == W'(DIV - 1));

   always_comb begin
      dcnt_d = tick ? '0 : dcnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dcnt_q <= '0;
      else      dcnt_q <= dcnt_d;
   end

endmodule

// File: rtl/vga_scan.sv
// VGA raster scan: h/v counters, visible-region address to the renderers,
// one-pixel delayed RGB/sync to the pins, and a per-frame strobe.
module vga_scan
   import vga_pkg::*;
#(
   parameter int DIV    = DIV_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int H_ACT  = H_ACT_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF,
   parameter int V_ACT  = V_ACT_DEF,
   parameter int V_FP   = V_FP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] d_in,
   output logic [8:0]  row,
   output logic [9:0]  col,
   output logic        rdn,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        hs,
   output logic        vs,
   output logic        frame_start
);

   localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BP + H_ACT + H_FP - 1);
   localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BP + V_ACT + V_FP - 1);
   localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_HI   = 10'(H_SYNC + H_BP + H_ACT);
   localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_HI   = 10'(V_SYNC + V_BP + V_ACT);
   localparam logic [9:0] H_SW   = 10'(H_SYNC);
   localparam logic [9:0] V_SW   = 10'(V_SYNC);

   logic        tick;
   logic [9:0]  h_q, h_d, v_q, v_d, h_nx, v_nx;
   logic        h_wrap, v_wrap, h_vis, v_vis;
   s1_t         s1_q, s1_d;
   logic [11:0] rgb_q, rgb_d;
   logic        hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

   pix_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      h_wrap = (h_q == H_LAST);
      v_wrap = (v_q == V_LAST);
      h_nx   = h_wrap ? '0 : h_q + 10'd1;
      v_nx   = v_q;
      if (h_wrap) v_nx = v_wrap ? '0 : v_q + 10'd1;

      // Region decode works on the post-increment counters so stage 1
      // describes the pixel the counters now hold.
      h_vis = in_win(h_nx, H_LO, H_HI);
      v_vis = in_win(v_nx, V_LO, V_HI);

      h_d   = h_q;
      v_d   = v_q;
      s1_d  = s1_q;
      rgb_d = rgb_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      fs_d  = tick && h_wrap && v_wrap;

      if (tick) begin
         h_d         = h_nx;
         v_d         = v_nx;
         s1_d.col    = h_vis ? h_nx - H_LO : '0;
         s1_d.row    = v_vis ? 9'(v_nx - V_LO) : '0;
         s1_d.rdn    = !(h_vis && v_vis);
         s1_d.hs_raw = (h_nx >= H_SW);
         s1_d.vs_raw = (v_nx >= V_SW);
         // Stage 2: renderers had a full pixel to answer for s1 row/col.
         rgb_d       = s1_q.rdn ? 12'h000 : d_in;
         hs_d        = s1_q.hs_raw;
         vs_d        = s1_q.vs_raw;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_q   <= '0;
         v_q   <= '0;
         s1_q  <= S1_RST;
         rgb_q <= 12'h000;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         fs_q  <= 1'b0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         s1_q  <= s1_d;
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         fs_q  <= fs_d;
      end
   end

   assign row         = s1_q.row;
   assign col         = s1_q.col;
   assign rdn         = s1_q.rdn;
   assign r           = rgb_q[11:8];
   assign g           = rgb_q[7:4];
   assign b           = rgb_q[3:0];
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan on a shrunken raster; expectations come from
// a pixel-index model (tick count mod frame size), not from counters.
module tb_vga_scan;

   localparam int DIV = 4;
   localparam int HS = 4, HB = 3, HA = 8, HF = 2;
   localparam int VS = 2, VB = 2, VA = 5, VF = 2;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] d_in;
   logic [8:0]  row;
   logic [9:0]  col;
   logic        rdn, hs, vs, frame_start;
   logic [3:0]  r, g, b;

   always #5 clk = ~clk;

   vga_scan #(
      .DIV(DIV), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF)
   ) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .row(row), .col(col), .rdn(rdn),
      .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .frame_start(frame_start)
   );

   typedef struct {
      logic [8:0] row;
      logic [9:0] col;
      logic       rdn, hs, vs;
   } pix_t;

   typedef struct {
      logic [8:0]  row;
      logic [9:0]  col;
      logic        rdn;
      logic [11:0] rgb;
      logic        hs, vs, fs;
   } exp_t;

   exp_t q[$];
   int checks = 0, failures = 0;
   logic        pat = 1'b1;
   logic [11:0] d_rand = 12'h000;
   logic        running = 1'b0;
   int          ecnt = 0, ntick = 0, last_fs = 0;
   logic [11:0] rgb_m = 12'h000;
   logic        hs_m = 1'b1, vs_m = 1'b1, fs_m = 1'b0;
   int          max_row = 0, max_col = 0;
   int          hs_falls = 0;
   logic        vs_armed = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;

   assign d_in = pat ? {row[3:0], col[3:0], 4'hA} : d_rand;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // State of stage 1 after n pixel ticks since reset release.
   function automatic pix_t stage1(input int n);
      pix_t p;
      int k, h, v;
      logic hv, vv;
      if (n == 0) begin
         p.row = '0; p.col = '0; p.rdn = 1'b1; p.hs = 1'b1; p.vs = 1'b1;
         return p;
      end
      k  = n % FRAME;
      h  = k % HT;
      v  = k / HT;
      hv = (h >= HS + HB) && (h < HS + HB + HA);
      vv = (v >= VS + VB) && (v < VS + VB + VA);
      p.rdn = !(hv && vv);
      p.col = hv ? 10'(h - HS - HB) : 10'd0;
      p.row = vv ? 9'(v - VS - VB) : 9'd0;
      p.hs  = (h >= HS);
      p.vs  = (v >= VS);
      return p;
   endfunction

   always @(negedge clk) d_rand <= 12'($urandom);

   // Driver/model: one expected record per clk after release.
   always @(posedge clk) begin
      pix_t prev, cur;
      exp_t x;
      if (running) begin
         ecnt++;
         fs_m = 1'b0;
         if (ecnt % DIV == 0) begin
            prev = stage1(ntick);
            if (prev.rdn) rgb_m = 12'h000;
            else rgb_m = pat ? {prev.row[3:0], prev.col[3:0], 4'hA} : d_rand;
            hs_m = prev.hs;
            vs_m = prev.vs;
            ntick++;
            fs_m = (ntick % FRAME == 0);
         end
         cur   = stage1(ntick);
         x.row = cur.row; x.col = cur.col; x.rdn = cur.rdn;
         x.rgb = rgb_m; x.hs = hs_m; x.vs = vs_m; x.fs = fs_m;
         q.push_back(x);
      end
   end

   // Monitor
   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("row", 32'(row), 32'(x.row));
         chk("col", 32'(col), 32'(x.col));
         chk("rdn", 32'(rdn), 32'(x.rdn));
         chk("rgb", 32'({r, g, b}), 32'(x.rgb));
         chk("hs", 32'(hs), 32'(x.hs));
         chk("vs", 32'(vs), 32'(x.vs));
         chk("frame_start", 32'(frame_start), 32'(x.fs));
         if (!rdn) begin
            if (int'(row) > max_row) max_row = int'(row);
            if (int'(col) > max_col) max_col = int'(col);
         end
         if (frame_start) begin
            chk("fs_interval", 32'(ecnt - last_fs), 32'(FRAME * DIV));
            last_fs = ecnt;
         end
         if (prev_hs && !hs) hs_falls++;
         if (prev_vs && !vs) begin
            if (vs_armed) chk("hs_per_frame", 32'(hs_falls), 32'(VT));
            hs_falls = 0;
            vs_armed = 1'b1;
         end
         prev_hs = hs;
         prev_vs = vs;
      end
   end

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_row"}, 32'(row), 32'd0);
      chk({tag, "_col"}, 32'(col), 32'd0);
      chk({tag, "_rdn"}, 32'(rdn), 32'd1);
      chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
      chk({tag, "_hs"}, 32'(hs), 32'd1);
      chk({tag, "_vs"}, 32'(vs), 32'd1);
      chk({tag, "_fs"}, 32'(frame_start), 32'd0);
   endtask

   task automatic release_rst();
      @(negedge clk);
      #2;
      ecnt = 0; ntick = 0; last_fs = 0;
      rgb_m = 12'h000; hs_m = 1'b1; vs_m = 1'b1; fs_m = 1'b0;
      hs_falls = 0; vs_armed = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
      rst = 1'b1;
      running = 1'b1;
   endtask

   initial begin
      #12;
      chk_reset_outs("por");
      release_rst();
      // Pattern mode: d_in follows row/col.
      repeat (2 * FRAME * DIV + 50) @(negedge clk);
      pat = 1'b0;
      repeat (2 * FRAME * DIV) @(negedge clk);
      // Asynchronous reset part-way through a frame.
      repeat ($urandom_range(FRAME * DIV / 3, 2 * FRAME * DIV / 3)) @(negedge clk);
      #2;
      running = 1'b0;
      rst = 1'b0;
      #1;
      chk_reset_outs("mid");
      q.delete();
      repeat (5) @(negedge clk);
      chk_reset_outs("held");
      release_rst();
      pat = 1'($urandom_range(0, 1));
      repeat (2 * FRAME * DIV + 20) @(negedge clk);
      chk("row_max", 32'(max_row), 32'(VA - 1));
      chk("col_max", 32'(max_col), 32'(HA - 1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
